// File: rtl/mem_pkg.sv
// Types and constants shared by the main-memory responder and its wait counter.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    localparam logic MRW_READ  = 1'b0;
    localparam logic MRW_WRITE = 1'b1;

    localparam int unsigned CTR_W = 8;

endpackage : mem_pkg

// File: rtl/mem_wait_ctr.sv
// Loadable down-counter that times the wait states of one memory access.
module mem_wait_ctr
    import mem_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CTR_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             done_o
);

    localparam logic [CTR_W-1:0] CNT_ZERO = '0;
    localparam logic [CTR_W-1:0] CNT_ONE  = CTR_W'(1);

    logic [CTR_W-1:0] cnt_q, cnt_d;

    // NOTE: cnt_d gets its hold value first so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != CNT_ZERO)) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A zero load means the access skips WAIT entirely.
    assign done_o = (dec_i && (cnt_q <= CNT_ONE)) || (load_i && (load_val_i == CNT_ZERO));

endmodule : mem_wait_ctr

// File: rtl/main_memory.sv
// Slow backing-store responder: latches one request, waits WAIT_CYCLES, then
// completes it against a word array with a one-cycle MReady pulse.
module main_memory
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MStrobe,
    input  logic              MRW,
    input  logic [ADDR_W-1:0] MAddr,
    input  logic [DATA_W-1:0] MDataIn,
    output logic [DATA_W-1:0] MDataOut,
    output logic              MReady,
    output logic              MBusy,
    output logic              MErr
);

    if (WAIT_CYCLES > 255) begin : g_bad_wait_cycles
        $error("main_memory: WAIT_CYCLES must be in 0..255");
    end

    localparam logic [CTR_W-1:0] WAIT_LOAD = CTR_W'(WAIT_CYCLES);

    mem_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rw_q, rw_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              accept;
    logic              ctr_done;
    logic              enter_resp;
    logic              mem_we;

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    assign accept = (state_q == IDLE) && MStrobe;

    mem_wait_ctr u_wait_ctr (
        .clk        (clk),
        .reset      (reset),
        .load_i     (accept),
        .load_val_i (WAIT_LOAD),
        .dec_i      (state_q == WAIT),
        .done_o     (ctr_done)
    );

    // The *_d request values equal the live inputs on the accept edge, so a
    // zero-wait access commits with the same signals as a delayed one.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        wdata_d = wdata_q;
        err_d   = MStrobe && (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (MStrobe) begin
                    addr_d  = MAddr;
                    rw_d    = MRW;
                    wdata_d = MDataIn;
                    state_d = ctr_done ? RESP : WAIT;
                end
            end
            WAIT:    if (ctr_done) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign enter_resp = (state_d == RESP) && (state_q != RESP);
    assign mem_we     = reset && enter_resp && (rw_d == MRW_WRITE);

    always_comb begin
        rdata_d = rdata_q;
        if (enter_resp && (rw_d == MRW_READ)) begin
            rdata_d = mem_q[addr_d];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rw_q    <= MRW_READ;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // NOTE: the array has no reset so it maps onto plain RAM; reset only gates the write enable.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[addr_d] <= wdata_d;
        end
    end

    assign MDataOut = rdata_q;
    assign MReady   = (state_q == RESP);
    assign MBusy    = (state_q != IDLE);
    assign MErr     = err_q;

endmodule : main_memory

// File: tb/tb_main_memory.sv
// Directed bench for main_memory: default 4-wait build plus a zero-wait build.
module tb_main_memory;

    logic        clk;
    logic        reset;
    logic        MStrobe, MRW;
    logic [7:0]  MAddr;
    logic [31:0] MDataIn, MDataOut;
    logic        MReady, MBusy, MErr;

    logic        s0_strobe, s0_rw;
    logic [7:0]  s0_addr;
    logic [31:0] s0_wdata, s0_rdata;
    logic        s0_ready, s0_busy, s0_err;

    int checks = 0;
    int errors = 0;

    main_memory #(.DATA_W(32), .ADDR_W(8), .WAIT_CYCLES(4)) u_dut (
        .clk(clk), .reset(reset), .MStrobe(MStrobe), .MRW(MRW), .MAddr(MAddr),
        .MDataIn(MDataIn), .MDataOut(MDataOut), .MReady(MReady), .MBusy(MBusy), .MErr(MErr)
    );

    main_memory #(.DATA_W(32), .ADDR_W(8), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset), .MStrobe(s0_strobe), .MRW(s0_rw), .MAddr(s0_addr),
        .MDataIn(s0_wdata), .MDataOut(s0_rdata), .MReady(s0_ready), .MBusy(s0_busy), .MErr(s0_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Accept edge E; sampled at negedges, MReady must be high only in the
    // cycle after E+4 (closing at E+5). busy_at >= 0 re-strobes at that index.
    task automatic access(input string tag, input logic rw, input logic [7:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rd,
                          input int busy_at, input bit churn);
        MStrobe = 1'b1;
        MRW     = rw;
        MAddr   = addr;
        MDataIn = wdata;
        step();
        MStrobe = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("%s.ready%0d", tag, i), MReady, (i == 4));
            check($sformatf("%s.busy%0d", tag, i), MBusy, 1'b1);
            check($sformatf("%s.err%0d", tag, i), MErr, (busy_at >= 0) && (i == busy_at + 1));
            if (i == 4 && rw == 1'b0) check($sformatf("%s.rdata", tag), MDataOut, exp_rd);
            MStrobe = (i == busy_at);
            if (churn) begin
                MAddr   = 8'($urandom);
                MDataIn = $urandom;
                MRW     = 1'($urandom);
            end
            step();
        end
        check($sformatf("%s.ready_end", tag), MReady, 1'b0);
        check($sformatf("%s.busy_end", tag), MBusy, 1'b0);
        check($sformatf("%s.err_end", tag), MErr, 1'b0);
    endtask

    task automatic access0(input string tag, input logic rw, input logic [7:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rd);
        s0_strobe = 1'b1;
        s0_rw     = rw;
        s0_addr   = addr;
        s0_wdata  = wdata;
        step();
        s0_strobe = 1'b0;
        check($sformatf("%s.ready0", tag), s0_ready, 1'b1);
        check($sformatf("%s.busy0", tag), s0_busy, 1'b1);
        if (rw == 1'b0) check($sformatf("%s.rdata", tag), s0_rdata, exp_rd);
        step();
        check($sformatf("%s.ready1", tag), s0_ready, 1'b0);
        check($sformatf("%s.busy1", tag), s0_busy, 1'b0);
    endtask

    initial begin
        reset     = 1'b0;
        MStrobe   = 1'b0; MRW = 1'b0; MAddr = '0; MDataIn = '0;
        s0_strobe = 1'b0; s0_rw = 1'b0; s0_addr = '0; s0_wdata = '0;
        step();
        step();
        check("rst.ready", MReady, 1'b0);
        check("rst.busy", MBusy, 1'b0);
        check("rst.err", MErr, 1'b0);
        check("rst.rdata", MDataOut, 32'h0);
        check("rst0.busy", s0_busy, 1'b0);
        reset = 1'b1;
        step();

        access("wr10", 1'b1, 8'h10, 32'hDEADBEEF, 32'h0, -1, 1'b0);
        access("rd10", 1'b0, 8'h10, 32'h0, 32'hDEADBEEF, -1, 1'b0);

        // Second strobe lands on edge E+2 and must be dropped.
        access("wr40_busy", 1'b1, 8'h40, 32'h0000A5A5, 32'h0, 1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("drop.ready%0d", i), MReady, 1'b0);
            check($sformatf("drop.busy%0d", i), MBusy, 1'b0);
        end
        access("rd40", 1'b0, 8'h40, 32'h0, 32'h0000A5A5, -1, 1'b0);

        access("wr00", 1'b1, 8'h00, 32'h1, 32'h0, -1, 1'b0);
        access("wrFF", 1'b1, 8'hFF, 32'h2, 32'h0, -1, 1'b0);
        access("rd00", 1'b0, 8'h00, 32'h0, 32'h1, -1, 1'b0);
        access("rdFF", 1'b0, 8'hFF, 32'h0, 32'h2, -1, 1'b0);

        access("wr33_churn", 1'b1, 8'h33, 32'h55AA1234, 32'h0, -1, 1'b1);
        access("rd33_churn", 1'b0, 8'h33, 32'h0, 32'h55AA1234, -1, 1'b1);

        // Reset during WAIT of an overwrite must abort it without committing.
        access("wr20", 1'b1, 8'h20, 32'h1234, 32'h0, -1, 1'b0);
        MStrobe = 1'b1; MRW = 1'b1; MAddr = 8'h20; MDataIn = 32'hCAFE;
        step();
        MStrobe = 1'b0;
        step();
        check("abort.busy_pre", MBusy, 1'b1);
        reset = 1'b0;
        #1;
        check("abort.busy", MBusy, 1'b0);
        check("abort.ready", MReady, 1'b0);
        check("abort.err", MErr, 1'b0);
        check("abort.rdata", MDataOut, 32'h0);
        step();
        reset = 1'b1;
        step();
        check("abort.ready_after", MReady, 1'b0);
        access("rd20", 1'b0, 8'h20, 32'h0, 32'h1234, -1, 1'b0);

        access0("w0_wr5", 1'b1, 8'h05, 32'h0BADF00D, 32'h0);
        access0("w0_rd5", 1'b0, 8'h05, 32'h0, 32'h0BADF00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_main_memory
